// File: rtl/timer_sched.sv
// Round-robin arbiter that lends one prescaled timer host to NUM_REQ requesters,
// sequencing start / wait-for-active / run / stop and reporting a completion status.
module timer_sched #(
  parameter int NUM_REQ     = 4,
  parameter int TIMER_WIDTH = 32,
  parameter int WD_CYCLES   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*TIMER_WIDTH-1:0] req_load,
  input  logic [NUM_REQ-1:0]             req_cancel,
  input  logic                           pause_all,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic [1:0]                     done_status,
  output logic                           busy,
  output logic [TIMER_WIDTH-1:0]         tmr_load,
  output logic                           tmr_start,
  output logic                           tmr_stop,
  output logic                           tmr_pause,
  input  logic                           tmr_overflow,
  input  logic                           tmr_match,
  input  logic                           tmr_active
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(WD_CYCLES + 1);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

  typedef enum logic [2:0] {IDLE, START, WAIT_ACT, RUN, STOP, DONE} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d, last_q, last_d;
  logic [TIMER_WIDTH-1:0] load_q, load_d;
  logic [1:0]             status_q, status_d, pend_q, pend_d;
  logic [WW-1:0]          wd_q, wd_d;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   cand;

  // Rotating priority: scan upward from the requester after the last owner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (IW+1)'(k);
      if (cand >= NR) cand = cand - NR;
      if (!found && req_valid[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    load_d   = load_q;
    status_d = status_q;
    pend_d   = pend_q;
    wd_d     = wd_q;
    case (state_q)
      IDLE: if (found) begin
        owner_d = pick;
        load_d  = req_load[pick*TIMER_WIDTH +: TIMER_WIDTH];
        state_d = START;
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (tmr_active) state_d = RUN;
        else if (wd_q == WW'(WD_CYCLES)) begin
          pend_d  = 2'b11;
          state_d = STOP;
        end else wd_d = wd_q + WW'(1);
      end
      RUN: begin
        if (req_cancel[owner_q]) begin
          pend_d  = 2'b10;
          state_d = STOP;
        end else if (tmr_overflow) begin
          // host has already idled itself, so skip the stop strobe
          status_d = 2'b00;
          state_d  = DONE;
        end else if (tmr_match) begin
          pend_d  = 2'b01;
          state_d = STOP;
        end
      end
      STOP: begin
        status_d = pend_q;
        state_d  = DONE;
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      load_q   <= '0;
      status_q <= 2'b00;
      pend_q   <= 2'b00;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      load_q   <= load_d;
      status_q <= status_d;
      pend_q   <= pend_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    grant       = '0;
    done        = '0;
    busy        = (state_q != IDLE);
    tmr_start   = (state_q == START);
    tmr_stop    = (state_q == STOP);
    tmr_pause   = (state_q == RUN) && pause_all;
    tmr_load    = (state_q == IDLE) ? '0 : load_q;
    done_status = status_q;
    case (state_q)
      START, WAIT_ACT, RUN, STOP: grant[owner_q] = 1'b1;
      DONE:                       done[owner_q]  = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: doc/timer_sched.md
# timer_sched

Round-robin scheduler that shares one timer host (32-bit prescaled timer with start/stop/pause, overflow and match flags) among `NUM_REQ` requesters. It grants the timer to one requester at a time, loads and starts the timer, and watches for match, overflow or cancel. It then stops the timer if needed and returns a one-cycle completion pulse with a status code. It sits between the requesting agents and the timer host's control ports.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMER_WIDTH`, 32, timer load width; matches the timer host
- `WD_CYCLES`, 4, watchdog limit for the timer to report active after start

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `req_valid`  in  NUM_REQ  per-requester request, level
- `req_load`  in  NUM_REQ*TIMER_WIDTH  packed load values; slice i = bits [i*TIMER_WIDTH +: TIMER_WIDTH]
- `req_cancel`  in  NUM_REQ  per-requester abort; only the granted bit is honoured
- `pause_all`  in  1  global pause request
- `grant`  out  NUM_REQ  one-hot owner of the timer, 0 when free
- `done`  out  NUM_REQ  one-cycle completion pulse to the owner
- `done_status`  out  2  00 overflow, 01 match, 10 cancelled, 11 watchdog error; valid with `done`, held until next `done`
- `busy`  out  1  high in every state except IDLE
- `tmr_load`  out  TIMER_WIDTH  load value to the timer host
- `tmr_start`  out  1  start strobe
- `tmr_stop`  out  1  stop strobe
- `tmr_pause`  out  1  pause level
- `tmr_overflow`  in  1  timer host overflow flag
- `tmr_match`  in  1  timer host match flag
- `tmr_active`  in  1  timer host active flag

## Operation
- FSM states: IDLE, START, WAIT_ACT, RUN, STOP, DONE.
  - Outputs are Moore decodes of the registered state plus registered `owner`, `load_q` and `status_q`.
- **IDLE**
  - If any `req_valid` is high, pick the first set bit searching from `(last+1) mod NUM_REQ` upward with wrap.
  - Latch `owner`, latch `load_q` from that requester's slice, then go to START.
  - Otherwise stay in IDLE.
- **START** (1 cycle)
  - `tmr_start`=1 and `tmr_load`=`load_q`. Go to WAIT_ACT and clear the watchdog counter.
- **WAIT_ACT**
  - If `tmr_active`, go to RUN.
  - Otherwise increment the watchdog. When it reaches `WD_CYCLES`, set status 11 and go to STOP.
- **RUN**, evaluated in priority order:
  - `req_cancel[owner]`: status 10, go to STOP.
  - `tmr_overflow`: status 00, go to DONE. The timer has already returned itself to idle, so no stop is issued.
  - `tmr_match`: status 01, go to STOP.
  - Otherwise stay in RUN.
  - `tmr_pause` = `pause_all` while in RUN and 0 in all other states.
  - `tmr_active` dropping during RUN is not treated as an error, because pause clears active.
- **STOP** (1 cycle)
  - `tmr_stop`=1, then go to DONE.
- **DONE** (1 cycle)
  - `done[owner]`=1 and `done_status`=`status_q`.
  - `last` <= `owner`, then go to IDLE.
- `grant[owner]`=1 in START, WAIT_ACT, RUN and STOP. It is 0 in IDLE and DONE.
- `tmr_load` holds `load_q` in all non-IDLE states and is 0 in IDLE.
- Requesters must drop `req_valid` on `done`. A request still high in IDLE is arbitrated as a new request.
- `req_load` changes after the latch cycle have no effect.
- `req_cancel` on non-owner bits, or outside RUN, is ignored.
  - Exception: a cancel in WAIT_ACT is not honoured. It is acted on once RUN is reached, if still held.

## Timing
- Reset:
  - All outputs are 0 (`done_status`=00) and the FSM is in IDLE.
  - `last`=`NUM_REQ-1`, so requester 0 has first priority.
  - Reset asserted mid-operation clears everything immediately. The in-flight request is dropped and no `done` is issued.
- Latency from `req_valid` sampled in IDLE (cycle t):
  - START, `grant` and `tmr_start` at t+1.
  - The timer host reports active at t+2, so RUN at t+3.
- RUN to `done`:
  - Overflow seen at cycle u: `done` at u+1.
  - Match or cancel seen at u: `tmr_stop` at u+1, `done` at u+2.
- Back-to-back requests: minimum gap between consecutive `tmr_start` pulses is 5 cycles (IDLE, START, WAIT_ACT, RUN, DONE). This guarantees the timer host has cleared its match flag before the next RUN.
- Simultaneous events in RUN resolve as cancel > overflow > match.
- Watchdog: with `tmr_active` never rising, `done` with status 11 arrives `WD_CYCLES`+3 cycles after START.

## Test plan
- Single request:
  - Stimulus: `req_valid`=0001, slice0=0x0000_00F0; host model asserts active one cycle after start, then match 20 cycles later.
  - Required: `grant`=0001 at t+1, `tmr_load`=0xF0 with `tmr_start` at t+1, one `tmr_stop` pulse, `done`=0001 with status 01.
- Round-robin fairness:
  - Stimulus: `req_valid`=1111 held, each requester re-raising after `done`.
  - Required: grant order 0,1,2,3,0; never two grant bits set at once.
- Overflow path:
  - Stimulus: slice2=0xFFFF_FFFF; host pulses overflow.
  - Required: `done`=0100 with status 00 one cycle later, and `tmr_stop` never asserted.
- Cancel vs match collision:
  - Stimulus: `req_cancel[owner]` and `tmr_match` high in the same RUN cycle.
  - Required: status 10, one `tmr_stop`.
  - A `req_cancel` on a non-owner bit has no effect.
- Watchdog and pause:
  - Stimulus: `tmr_active` held 0.
  - Required: status 11 with a `tmr_stop` pulse; `done` 7 cycles after START.
  - Separately, `pause_all` during RUN drives `tmr_pause`=1, and `pause_all` in IDLE leaves `tmr_pause`=0.
- Reset mid-RUN:
  - Stimulus: drive `rst`=0 for one cycle.
  - Required: `grant`, `busy`, `tmr_*` and `done` go to 0 immediately; the next arbitration starts from requester 0.
